// File: rtl/axi4_wr_fifo_packer_if.sv
// AXI4 write-channel bundle (AW/W/B) between an upstream master and the FIFO packer.
interface axi4_wr_fifo_packer_if #(
  parameter int unsigned data_wid = 64,
  parameter int unsigned adr_wid  = 32,
  parameter int unsigned id_wid   = 8,
  parameter int unsigned len_wid  = 8,
  parameter int unsigned strb_wid = data_wid / 8
);
  logic [id_wid-1:0]   AWID_a;
  logic [adr_wid-1:0]  AWADDR_a;
  logic [len_wid-1:0]  AWLEN_a;
  logic [2:0]          AWSIZE_a;
  logic [1:0]          AWBURST_a;
  logic                AWVALID_a;
  logic                AWREADY_a;
  logic [data_wid-1:0] WDATA_a;
  logic [strb_wid-1:0] WSTRB_a;
  logic                WLAST_a;
  logic                WVALID_a;
  logic                WREADY_a;
  logic [id_wid-1:0]   BID_a;
  logic [1:0]          BRESP_a;
  logic                BVALID_a;
  logic                BREADY_a;

  modport master (
    output AWID_a, AWADDR_a, AWLEN_a, AWSIZE_a, AWBURST_a, AWVALID_a,
    output WDATA_a, WSTRB_a, WLAST_a, WVALID_a, BREADY_a,
    input  AWREADY_a, WREADY_a, BID_a, BRESP_a, BVALID_a
  );

  modport slave (
    input  AWID_a, AWADDR_a, AWLEN_a, AWSIZE_a, AWBURST_a, AWVALID_a,
    input  WDATA_a, WSTRB_a, WLAST_a, WVALID_a, BREADY_a,
    output AWREADY_a, WREADY_a, BID_a, BRESP_a, BVALID_a
  );
endinterface

// File: rtl/axi4_wr_fifo_packer.sv
// AXI4 write slave: packs pairs of 64-bit INCR beats into 128-bit FIFO pushes,
// one B response per burst; malformed bursts are drained without pushing.
module axi4_wr_fifo_packer #(
  parameter int unsigned data_wid = 64,
  parameter int unsigned adr_wid  = 32,
  parameter int unsigned id_wid   = 8,
  parameter int unsigned len_wid  = 8,
  parameter int unsigned strb_wid = data_wid / 8,
  parameter int unsigned fifo_wid = 2 * data_wid
) (
  input  logic                  clk,
  input  logic                  rst,
  axi4_wr_fifo_packer_if.slave  axi,
  output logic                  wr_en,
  output logic [fifo_wid-1:0]   wr_data,
  input  logic                  full
);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  state_e              state_q, state_d;
  logic [id_wid-1:0]   id_q, id_d;
  logic [len_wid-1:0]  len_q, len_d;
  logic [len_wid-1:0]  cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                wlerr_q, wlerr_d;
  logic [data_wid-1:0] half_q, half_d;
  logic                half_vld_q, half_vld_d;

  logic [data_wid-1:0] wdata_m;
  logic                final_beat;
  logic                push_cand;
  logic                awready_c, wready_c, bvalid_c;
  logic [id_wid-1:0]   bid_c;
  logic [1:0]          bresp_c;
  logic                unused_addr;

  assign unused_addr = ^axi.AWADDR_a;

  assign axi.AWREADY_a = awready_c;
  assign axi.WREADY_a  = wready_c;
  assign axi.BVALID_a  = bvalid_c;
  assign axi.BID_a     = bid_c;
  assign axi.BRESP_a   = bresp_c;

  always_comb begin
    wdata_m = '0;
    for (int unsigned i = 0; i < strb_wid; i++) begin
      if (axi.WSTRB_a[i]) wdata_m[i*8 +: 8] = axi.WDATA_a[i*8 +: 8];
    end
  end

  assign final_beat = (cnt_q == len_q);
  // Candidate push is computed without WREADY so the ready/full path has no loop.
  assign push_cand  = (state_q == DATA) && axi.WVALID_a && (half_vld_q || final_beat);

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    wlerr_d    = wlerr_q;
    half_d     = half_q;
    half_vld_d = half_vld_q;
    awready_c  = 1'b0;
    wready_c   = 1'b0;
    bvalid_c   = 1'b0;
    bid_c      = '0;
    bresp_c    = '0;
    wr_en      = 1'b0;
    wr_data    = '0;

    unique case (state_q)
      IDLE: begin
        awready_c = 1'b1;
        if (axi.AWVALID_a) begin
          id_d       = axi.AWID_a;
          len_d      = axi.AWLEN_a;
          err_d      = (axi.AWSIZE_a != 3'd3) || (axi.AWBURST_a != 2'b01);
          wlerr_d    = 1'b0;
          cnt_d      = '0;
          half_d     = '0;
          half_vld_d = 1'b0;
          state_d    = DATA;
        end
      end
      DATA: begin
        wready_c = !push_cand || !full || err_q;
        if (axi.WVALID_a && wready_c) begin
          cnt_d = cnt_q + len_wid'(1);
          if (axi.WLAST_a != final_beat) wlerr_d = 1'b1;
          if (!half_vld_q && !final_beat) begin
            half_d     = wdata_m;
            half_vld_d = 1'b1;
          end else begin
            half_vld_d = 1'b0;
          end
          if (push_cand && !err_q) begin
            wr_en   = 1'b1;
            wr_data = half_vld_q ? {wdata_m, half_q} : {{data_wid{1'b0}}, wdata_m};
          end
          if (final_beat) state_d = RESP;
        end
      end
      RESP: begin
        bvalid_c = 1'b1;
        bid_c    = id_q;
        bresp_c  = (err_q || wlerr_q) ? 2'b10 : 2'b00;
        if (axi.BREADY_a) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are forced quiet for the whole reset window, not just after the edge.
    if (rst) begin
      awready_c = 1'b0;
      wready_c  = 1'b0;
      bvalid_c  = 1'b0;
      bid_c     = '0;
      bresp_c   = '0;
      wr_en     = 1'b0;
      wr_data   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      id_q       <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      wlerr_q    <= 1'b0;
      half_q     <= '0;
      half_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      wlerr_q    <= wlerr_d;
      half_q     <= half_d;
      half_vld_q <= half_vld_d;
    end
  end

endmodule
